// File: rtl/rng_pkg.sv
// ----------------------------------------------------------------------------
// rng_pkg
// Shared types and constants for the RSA key-gen random word arbiter.
//   state_t : arbiter FSM encoding (IDLE / WAIT / DONE)
//   LFSR_W  : width of one LFSR sample
//   nchunk  : number of LFSR samples needed to build a word of word_w bits
// ----------------------------------------------------------------------------
package rng_pkg;

    localparam int LFSR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int word_w);
        return word_w / LFSR_W;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: lowest requesting index strictly above
// last_gnt, wrapping around. The caller registers the result.
//   req      in  NREQ   request vector (already masked by the caller)
//   last_gnt in  GW     index granted last
//   win      out GW     winning index (valid when any_req)
//   any_req  out 1      at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_gnt,
    output logic [GW-1:0]   win,
    output logic            any_req
);

    // Walk offsets from farthest to nearest so the nearest requester above
    // last_gnt overwrites the others and wins.
    always_comb begin
        win     = '0;
        any_req = |req;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_gnt) + k) % NREQ;
            if (req[idx]) win = GW'(idx);
        end
    end

endmodule

// File: rtl/rng_request_arbiter.sv
// ----------------------------------------------------------------------------
// rng_request_arbiter
// Shares one free-running 32-bit LFSR among NREQ requesters. A granted
// requester receives a WORD_W-bit word assembled from LFSR samples taken
// SPACING cycles apart (first sample in the MS chunk), optionally formatted
// as an odd full-width prime candidate.
//   clk, rst   clock; synchronous active-high reset
//   lfsr_en    out  LFSR enable, high from the first cycle after reset
//   rng_in     in   current LFSR output
//   req        in   level request per requester, held until ack
//   fmt_odd    in   per requester: force MSB and LSB of the word to 1
//   ack        out  one-hot, one-cycle; rnd_data valid in that cycle
//   rnd_data   out  delivered word, held until the next delivery
//   busy       out  high while a word is assembled or delivered
// ----------------------------------------------------------------------------
module rng_request_arbiter
    import rng_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int WORD_W  = 64,
    parameter int SPACING = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              lfsr_en,
    input  logic [LFSR_W-1:0] rng_in,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   fmt_odd,
    output logic [NREQ-1:0]   ack,
    output logic [WORD_W-1:0] rnd_data,
    output logic              busy
);

    localparam int NCHUNK = nchunk(WORD_W);
    localparam int GW     = $clog2(NREQ);
    localparam int SW     = $clog2(SPACING);
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WORD_W-1:0] ODD_BITS = {1'b1, {(WORD_W-2){1'b0}}, 1'b1};

    state_t            r_state;
    logic [GW-1:0]     r_last_gnt;
    logic [GW-1:0]     r_win;
    logic              r_fmt;
    logic [CW-1:0]     r_chunk;
    logic [SW-1:0]     r_cnt;
    logic [WORD_W-1:0] r_asm;
    logic [NREQ-1:0]   r_mask;
    logic [NREQ-1:0]   r_ack;
    logic [WORD_W-1:0] r_data;
    logic              r_busy;
    logic              r_lfsr_en;

    logic [NREQ-1:0]   w_req_m;
    logic [GW-1:0]     w_win;
    logic              w_any;
    logic [WORD_W-1:0] w_asm_nxt;

    // The requester just served still holds req until it sees ack, so it is
    // hidden for exactly the one IDLE cycle that follows DONE.
    assign w_req_m = req & ~r_mask;

    rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_rr (
        .req      (w_req_m),
        .last_gnt (r_last_gnt),
        .win      (w_win),
        .any_req  (w_any)
    );

    generate
        if (NCHUNK == 1) begin : g_one
            assign w_asm_nxt = rng_in;
        end else begin : g_shift
            assign w_asm_nxt = {r_asm[WORD_W-LFSR_W-1:0], rng_in};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last_gnt <= GW'(NREQ - 1);
            r_win      <= '0;
            r_fmt      <= 1'b0;
            r_chunk    <= '0;
            r_cnt      <= '0;
            r_asm      <= '0;
            r_mask     <= '0;
            r_ack      <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_lfsr_en  <= 1'b0;
        end else begin
            r_lfsr_en <= 1'b1;
            r_ack     <= '0;
            case (r_state)
                IDLE: begin
                    r_mask <= '0;
                    if (w_any) begin
                        r_win   <= w_win;
                        r_fmt   <= fmt_odd[w_win];
                        r_chunk <= '0;
                        r_cnt   <= SW'(SPACING - 1);
                        r_busy  <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_asm <= w_asm_nxt;
                        if (r_chunk == CW'(NCHUNK - 1)) begin
                            r_state <= DONE;
                        end else begin
                            r_chunk <= r_chunk + CW'(1);
                            r_cnt   <= SW'(SPACING - 1);
                        end
                    end else begin
                        r_cnt <= r_cnt - SW'(1);
                    end
                end
                DONE: begin
                    r_data     <= r_fmt ? (r_asm | ODD_BITS) : r_asm;
                    r_ack      <= NREQ'(1) << r_win;
                    r_mask     <= NREQ'(1) << r_win;
                    r_last_gnt <= r_win;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lfsr_en  = r_lfsr_en;
    assign ack      = r_ack;
    assign rnd_data = r_data;
    assign busy     = r_busy;

endmodule

// File: tb/tb_rng_request_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rng_request_arbiter
// Directed bench: a Galois LFSR model supplies rng_in and logs the value the
// DUT sees at every clock edge, so expected words are rebuilt from the edge
// indices where captures must happen (grant edge + 32, + 64).
// ----------------------------------------------------------------------------
module tb_rng_request_arbiter;

    localparam logic [63:0] ODD = {1'b1, 62'd0, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lfsr_en;
    logic [31:0] lfsr = 32'hD4A56AAD;
    logic [1:0]  req = 2'b00;
    logic [1:0]  fmt_odd = 2'b00;
    logic [1:0]  ack;
    logic [63:0] rnd_data;
    logic        busy;

    int          ecount = 0;
    logic [31:0] hist [0:4095];
    int          n_chk = 0;
    int          n_err = 0;
    int          last_e;

    always #5 clk = ~clk;

    rng_request_arbiter #(.NREQ(2), .WORD_W(64), .SPACING(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .lfsr_en  (lfsr_en),
        .rng_in   (lfsr),
        .req      (req),
        .fmt_odd  (fmt_odd),
        .ack      (ack),
        .rnd_data (rnd_data),
        .busy     (busy)
    );

    function automatic logic [31:0] lfsr_nxt(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
    endfunction

    // hist[n] is the rng_in value the DUT samples at edge n.
    always @(posedge clk) begin
        hist[ecount % 4096] <= lfsr;
        ecount              <= ecount + 1;
        if (lfsr_en) lfsr <= lfsr_nxt(lfsr);
    end

    function automatic logic [63:0] expw(input int t);
        return {hist[(t + 32) % 4096], hist[(t + 64) % 4096]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bounded wait for an ack; e = edge index at which ack was registered.
    task automatic wait_ack(output int e, output logic [1:0] a);
        bit seen;
        seen = 1'b0;
        e    = -1;
        a    = 2'b00;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                seen = 1'b1;
                e    = ecount - 1;
                a    = ack;
            end
        end
    endtask

    task automatic run_chk(input string tag, input int t, input logic fmt, input logic [1:0] eack);
        int          e;
        logic [1:0]  a;
        logic [63:0] w;
        wait_ack(e, a);
        chk({tag, "_ack"}, 64'(a), 64'(eack));
        chk({tag, "_lat"}, 64'(e - t), 64'(65));
        w = expw(t);
        if (fmt) w = w | ODD;
        chk({tag, "_data"}, rnd_data, w);
        last_e = e;
    endtask

    initial begin
        int          t;
        int          nack;
        logic [63:0] prev;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ack",  64'(ack), 64'(0));
        chk("rst_data", rnd_data, 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_en",   64'(lfsr_en), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("en_up", 64'(lfsr_en), 64'(1));
        repeat (2) @(negedge clk);

        // single request; req held one cycle past ack exercises the mask
        req = 2'b01; fmt_odd = 2'b00; t = ecount;
        @(negedge clk);
        chk("busy_up", 64'(busy), 64'(1));
        run_chk("single", t, 1'b0, 2'b01);
        @(negedge clk);
        chk("mask_busy", 64'(busy), 64'(0));
        chk("ack_pulse", 64'(ack), 64'(0));
        req = 2'b00;
        repeat (2) @(negedge clk);

        // odd formatting on requester 1
        req = 2'b10; fmt_odd = 2'b10; t = ecount;
        run_chk("odd", t, 1'b1, 2'b10);
        chk("odd_msb", 64'(rnd_data[63]), 64'(1));
        chk("odd_lsb", 64'(rnd_data[0]), 64'(1));
        req = 2'b00; fmt_odd = 2'b00;
        repeat (3) @(negedge clk);

        // contention: both held, each drops one cycle after its ack
        req = 2'b11; t = ecount;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ea;
            ea = (k % 2 == 0) ? 2'b01 : 2'b10;
            run_chk($sformatf("cont%0d", k), t, 1'b0, ea);
            t = last_e + 1;
            if (k == 3) begin
                req = 2'b00;
            end else begin
                @(negedge clk);
                req = req & ~ea;
                @(negedge clk);
                req = 2'b11;
            end
        end
        repeat (3) @(negedge clk);

        // abort: reset 20 cycles into WAIT
        req = 2'b01; t = ecount;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_ack",  64'(ack), 64'(0));
        chk("abort_data", rnd_data, 64'(0));
        @(negedge clk);
        chk("abort_ack2", 64'(ack), 64'(0));
        rst = 1'b0; t = ecount;
        run_chk("abort_re", t, 1'b0, 2'b01);
        prev = expw(t);
        req = 2'b00;
        repeat (2) @(negedge clk);

        // mid-transaction req drop and fmt_odd toggle
        req = 2'b10; fmt_odd = 2'b10; t = ecount;
        repeat (10) @(negedge clk);
        chk("hold_data", rnd_data, prev);
        req = 2'b00; fmt_odd = 2'b01;
        run_chk("mid", t, 1'b1, 2'b10);
        nack = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ack != 2'b00) nack++;
        end
        chk("mid_once", 64'(nack), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rng_request_arbiter.md
Name: rng_request_arbiter

Overview:
- Shares the free-running 32-bit LFSR random source among NREQ requesters in the RSA key-generation datapath, such as the p/q prime candidate generators and the exponent generator.
- Holds the LFSR enabled permanently, so the moment the user presses start acts as the entropy.
- Builds a WORD_W-bit random word from spaced 32-bit samples, so no two samples share a shifted bit, and hands the word to one requester at a time in round-robin order.
- Can format the word as an odd, full-width prime candidate.

Parameters:
- NREQ, 2, number of requesters (>=2).
- WORD_W, 64, output word width; multiple of 32, >=32.
- SPACING, 32, LFSR clock cycles between captured samples; >=32 so each sample is fully new bits.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, synchronous, active-high.
- lfsr_en  out  1  enable to the LFSR.
- rng_in  in  32  current LFSR output.
- req  in  NREQ  level request per requester; held until its ack.
- fmt_odd  in  NREQ  per requester: force bit WORD_W-1 and bit 0 of the delivered word to 1.
- ack  out  NREQ  one-hot, one-cycle pulse; rnd_data is valid for that requester in that cycle.
- rnd_data  out  WORD_W  delivered random word; shared bus.
- busy  out  1  high while a word is being assembled or delivered.

Behaviour:
- Reset values:
  - lfsr_en=0, ack=0, rnd_data=0, busy=0.
  - State IDLE; last_gnt=NREQ-1, so req[0] wins first.
  - Chunk counter and spacing counter cleared.
- lfsr_en: registered; goes to 1 on the first cycle after rst deasserts and stays 1.
- NCHUNK = WORD_W/32.
- FSM states: IDLE, WAIT, DONE.
- IDLE, when (req & ~mask) != 0:
  - Round-robin pick: the lowest index strictly above last_gnt, wrapping.
  - Latch the winner index and fmt_odd[winner].
  - chunk=0, cnt=SPACING-1, go to WAIT.
  - busy=1 from the next cycle.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==0, capture: asm <= {asm[WORD_W-33:0], rng_in}, so the first sample lands in the MS chunk.
  - If chunk==NCHUNK-1, go to DONE; otherwise chunk++, cnt=SPACING-1, stay in WAIT.
- DONE, single cycle:
  - rnd_data <= asm, with bit WORD_W-1 and bit 0 forced to 1 if the latched fmt_odd is set.
  - ack[winner]=1; ack and rnd_data are registered and appear together.
  - last_gnt=winner, go to IDLE.
  - busy drops in the IDLE cycle.
- Latency:
  - IDLE sample at cycle t → captures at t+k*SPACING, k=1..NCHUNK → ack at t+NCHUNK*SPACING+1.
  - Defaults: 65 cycles.
- Re-grant mask:
  - In the IDLE cycle immediately after DONE, the just-acked requester's req is masked, because that requester cannot drop req until it sees ack.
  - The mask is cleared otherwise.
- rnd_data holds its value until the next DONE; no change while ack=0.
- Boundary cases:
  - Requests arriving during WAIT/DONE wait; at most one grant is in flight.
  - Simultaneous requests: round-robin order; no starvation, worst-case wait of NREQ-1 transactions.
  - req dropped mid-transaction: the word still completes and ack still pulses (requester ignores it); the grant is not aborted.
  - fmt_odd changing mid-transaction: ignored; only the value latched at grant is used.
  - rst mid-transaction: immediate return to the reset state; the partial word is discarded and no ack is issued.
  - The spacing counter is $clog2(SPACING) bits wide and never wraps past SPACING-1.

Decomposition:
- Package rng_pkg:
  - State encoding IDLE/WAIT/DONE.
  - LFSR_W=32.
  - Helper function computing NCHUNK.
- Sub-module rr_arbiter (NREQ):
  - Inputs: req vector, last_gnt.
  - Outputs: winner index, any_req.
  - Purely combinational; the FSM registers its result.

Test Plan:
- Reset release → lfsr_en 0 then 1 one cycle later; ack=0, rnd_data=0, busy=0.
- Single request:
  - Stimulus: req=01, fmt_odd=00, LFSR model seeded 0xD4A56AAD.
  - Expected: ack=01 exactly 65 cycles after the IDLE sample; rnd_data = {LFSR value at capture 1, LFSR value at capture 2}, with captures 32 cycles apart.
- Odd formatting: req=10, fmt_odd=10 → rnd_data[63]=1 and rnd_data[0]=1; other bits match the model.
- Contention:
  - Stimulus: req=11 held continuously, each requester dropping req one cycle after its ack then reasserting.
  - Expected: acks alternate 01,10,01,10; never two consecutive to the same requester.
- Abort: rst asserted 20 cycles into WAIT → no ack, busy=0 next cycle; a new req=01 afterwards is served with full 65-cycle latency.
- Mid-transaction change: req dropped mid-WAIT, fmt_odd toggled → ack still pulses once; formatting follows the value latched at grant.
